// File: rtl/mac_rx_frame_buffer_pkg.sv
// mac_rx_pkg: shared definitions for the MAC RX frame buffer slice.
//   - FIFO word layout {tlast, tkeep, tdata} expressed as field offsets
//   - clog2 helper and the legal OUT_BYTES check
//   - drop-reason encoding (DROP_ERR, DROP_OVF)
// No ports (package).
package mac_rx_pkg;

    typedef enum logic [1:0] {
        DROP_NONE = 2'd0,
        DROP_ERR  = 2'd1,
        DROP_OVF  = 2'd2
    } drop_reason_e;

    localparam int unsigned FIFO_DATA_LSB = 0;

    function automatic int unsigned fifo_keep_lsb(input int unsigned out_bytes);
        return 8 * out_bytes;
    endfunction

    function automatic int unsigned fifo_last_bit(input int unsigned out_bytes);
        return 9 * out_bytes;
    endfunction

    function automatic int unsigned fifo_width(input int unsigned out_bytes);
        return 9 * out_bytes + 1;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic bit out_bytes_legal(input int unsigned out_bytes);
        return (out_bytes == 1) || (out_bytes == 2) || (out_bytes == 4) || (out_bytes == 8);
    endfunction

endpackage

// File: rtl/mac_rx_frame_buffer_if.sv
// mac_rx_frame_buffer_if: AXI-Stream output bus of the MAC RX frame buffer.
//   tdata  [8*OUT_BYTES-1:0]  packed little-endian data
//   tkeep  [OUT_BYTES-1:0]    contiguous byte enables from bit 0
//   tvalid / tlast            word valid / last word of frame
//   tready                    downstream ready
// Modports: master (buffer side), slave (consumer side).
interface mac_rx_frame_buffer_if #(
    parameter int unsigned OUT_BYTES = 4
) ();
    logic [8*OUT_BYTES-1:0] tdata;
    logic [OUT_BYTES-1:0]   tkeep;
    logic                   tvalid;
    logic                   tlast;
    logic                   tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mac_rx_frame_buffer_packer.sv
// mac_rx_byte_packer: packs 8-bit MAC bytes into OUT_BYTES-wide words.
//   clk_125, clk_125_rstn      clock, asynchronous active-low reset
//   in_data/in_valid/in_last   MAC byte stream (no backpressure)
//   word_valid                 a word completes this cycle (full, or tlast)
//   word_data/keep/last        the completed word; unused lanes are 0
// The output word is combinational so it can be written in the same cycle
// the completing byte arrives.
module mac_rx_byte_packer
    import mac_rx_pkg::*;
#(
    parameter int unsigned OUT_BYTES = 4
) (
    input  logic                   clk_125,
    input  logic                   clk_125_rstn,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   word_valid,
    output logic [8*OUT_BYTES-1:0] word_data,
    output logic [OUT_BYTES-1:0]   word_keep,
    output logic                   word_last
);
    localparam int unsigned LW = (OUT_BYTES > 1) ? clog2(OUT_BYTES) : 1;

    logic [LW-1:0]          lane;
    logic [8*OUT_BYTES-1:0] acc;
    logic [OUT_BYTES-1:0]   keep_acc;

    // acc is cleared on every emitted word, so lanes above the current one
    // are always zero and a partial word needs no extra masking.
    always_comb begin
        word_data = acc;
        word_keep = keep_acc;
        for (int unsigned i = 0; i < OUT_BYTES; i++) begin
            if (LW'(i) == lane) begin
                word_data[8*i +: 8] = in_data;
                word_keep[i]        = 1'b1;
            end
        end
        word_valid = in_valid && ((lane == LW'(OUT_BYTES - 1)) || in_last);
        word_last  = in_valid && in_last;
    end

    always_ff @(posedge clk_125 or negedge clk_125_rstn) begin
        if (!clk_125_rstn) begin
            lane     <= '0;
            acc      <= '0;
            keep_acc <= '0;
        end else if (in_valid) begin
            if (word_valid) begin
                lane     <= '0;
                acc      <= '0;
                keep_acc <= '0;
            end else begin
                lane     <= lane + 1'b1;
                acc      <= word_data;
                keep_acc <= word_keep;
            end
        end
    end
endmodule

// File: rtl/mac_rx_frame_buffer.sv
// mac_rx_frame_buffer: store-and-forward RX frame FIFO between the 8-bit MAC
// RX client stream and a backpressured AXI-Stream master.
//   clk_125, clk_125_rstn   only clock; asynchronous active-low reset
//   s_mac_t{data,valid,last,user}  MAC RX byte stream, tuser = bad frame at tlast
//   m_axis                  AXI-Stream master (mac_rx_frame_buffer_if.master)
//   drop_pulse              one-cycle pulse per dropped frame
// Optional macro MAC_RX_STATS_EN adds saturating counters stat_good,
// stat_drop_err (tuser/oversize) and stat_drop_ovf (FIFO overflow).
// Frames are dropped on tuser, on exceeding MAX_FRAME bytes, or on overflow;
// only whole good frames are presented on m_axis.
module mac_rx_frame_buffer
    import mac_rx_pkg::*;
#(
    parameter int unsigned OUT_BYTES = 4,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic                  clk_125,
    input  logic                  clk_125_rstn,
    input  logic [7:0]            s_mac_tdata,
    input  logic                  s_mac_tvalid,
    input  logic                  s_mac_tlast,
    input  logic                  s_mac_tuser,
    mac_rx_frame_buffer_if.master m_axis,
    output logic                  drop_pulse
`ifdef MAC_RX_STATS_EN
    ,
    output logic [31:0]           stat_good,
    output logic [31:0]           stat_drop_err,
    output logic [31:0]           stat_drop_ovf
`endif
);
    localparam int unsigned AW       = clog2(DEPTH);
    localparam int unsigned WW       = fifo_width(OUT_BYTES);
    localparam int unsigned KEEP_LSB = fifo_keep_lsb(OUT_BYTES);
    localparam int unsigned LAST_BIT = fifo_last_bit(OUT_BYTES);
    localparam int unsigned CW       = clog2(MAX_FRAME + 1);

    if (!out_bytes_legal(OUT_BYTES) || (DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_bad_params
        $error("mac_rx_frame_buffer: illegal OUT_BYTES or DEPTH");
    end

    logic                   w_valid;
    logic                   w_last;
    logic [8*OUT_BYTES-1:0] w_data;
    logic [OUT_BYTES-1:0]   w_keep;

    mac_rx_byte_packer #(.OUT_BYTES(OUT_BYTES)) u_packer (
        .clk_125      (clk_125),
        .clk_125_rstn (clk_125_rstn),
        .in_data      (s_mac_tdata),
        .in_valid     (s_mac_tvalid),
        .in_last      (s_mac_tlast),
        .word_valid   (w_valid),
        .word_data    (w_data),
        .word_keep    (w_keep),
        .word_last    (w_last)
    );

    logic [WW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   wr_cmt;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] byte_cnt;
    drop_reason_e  reason_q;
    drop_reason_e  reason_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          oversize;
    logic          need_write;
    logic          mem_we;
    logic          frame_end;
    logic [WW-1:0] wr_word;
    logic [WW-1:0] rd_word;
    logic          out_valid;
    logic [WW-1:0] out_word;
    logic          load;

    // One slot is kept free: full when the next write would land on rd_ptr.
    assign fifo_full  = ((wr_ptr + 1'b1) == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign fifo_empty = (rd_ptr == wr_cmt);
    assign frame_end  = s_mac_tvalid && s_mac_tlast;

    // Overflow only counts when the frame still wanted to write; an overflow
    // takes precedence over an error seen in the same frame.
    always_comb begin
        oversize   = byte_cnt >= CW'(MAX_FRAME);
        need_write = s_mac_tvalid && w_valid && (reason_q == DROP_NONE);
        reason_d   = reason_q;
        if (need_write && fifo_full) begin
            reason_d = DROP_OVF;
        end else if (s_mac_tvalid && (reason_q == DROP_NONE) &&
                     (oversize || (s_mac_tlast && s_mac_tuser))) begin
            reason_d = DROP_ERR;
        end
        mem_we = need_write && (reason_d == DROP_NONE);

        wr_word                                 = '0;
        wr_word[FIFO_DATA_LSB +: 8*OUT_BYTES]   = w_data;
        wr_word[KEEP_LSB +: OUT_BYTES]          = w_keep;
        wr_word[LAST_BIT]                       = w_last;
    end

    always_ff @(posedge clk_125) begin
        if (mem_we) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk_125 or negedge clk_125_rstn) begin
        if (!clk_125_rstn) begin
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            byte_cnt   <= '0;
            reason_q   <= DROP_NONE;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (frame_end) begin
                byte_cnt <= '0;
                reason_q <= DROP_NONE;
                if (reason_d == DROP_NONE) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    wr_cmt <= wr_ptr + 1'b1;
                end else begin
                    wr_ptr     <= wr_cmt;
                    drop_pulse <= 1'b1;
                end
            end else if (s_mac_tvalid) begin
                if (!oversize) begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
                reason_q <= reason_d;
                if (mem_we) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // Registered first-word-fall-through output stage.
    assign rd_word = mem[rd_ptr[AW-1:0]];
    assign load    = !fifo_empty && (!out_valid || m_axis.tready);

    always_ff @(posedge clk_125 or negedge clk_125_rstn) begin
        if (!clk_125_rstn) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (load) begin
            out_word  <= rd_word;
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
        end else if (m_axis.tready) begin
            out_valid <= 1'b0;
        end
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_word[LAST_BIT];
    assign m_axis.tkeep  = out_word[KEEP_LSB +: OUT_BYTES];
    assign m_axis.tdata  = out_word[FIFO_DATA_LSB +: 8*OUT_BYTES];

`ifdef MAC_RX_STATS_EN
    always_ff @(posedge clk_125 or negedge clk_125_rstn) begin
        if (!clk_125_rstn) begin
            stat_good     <= '0;
            stat_drop_err <= '0;
            stat_drop_ovf <= '0;
        end else if (frame_end) begin
            if (reason_d == DROP_NONE) begin
                if (stat_good != '1) stat_good <= stat_good + 1'b1;
            end else if (reason_d == DROP_OVF) begin
                if (stat_drop_ovf != '1) stat_drop_ovf <= stat_drop_ovf + 1'b1;
            end else begin
                if (stat_drop_err != '1) stat_drop_err <= stat_drop_err + 1'b1;
            end
        end
    end
`endif
endmodule
